// File: rtl/victim_write_buffer.sv
// Posted write-back buffer between the victim cache and physical memory.
// Latency: write ack 1 cycle after request (not full); read hit 1 cycle; read miss = pmem latency + 1.
// Backpressure: requests are held upstream until mem_resp; a full buffer drains its head first.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mem_read/mem_write/mem_address/mem_wdata/mem_rdata/mem_resp   victim-cache side
//   pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp   physical-memory side
//   count, empty                   occupancy status
// Optional feature macro: WB_READ_FWD_EN (serve read hits straight from the buffer).
module victim_write_buffer #(
  parameter int DEPTH       = 4,
  parameter int LINE_BITS   = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [15:0]                mem_address,
  input  logic [LINE_BITS-1:0]       mem_wdata,
  output logic [LINE_BITS-1:0]       mem_rdata,
  output logic                       mem_resp,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [15:0]                pmem_address,
  output logic [LINE_BITS-1:0]       pmem_wdata,
  input  logic [LINE_BITS-1:0]       pmem_rdata,
  input  logic                       pmem_resp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LA = 16 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, ACK, MEM_RD, DRAIN} state_t;

  state_t               state;
  logic [DEPTH-1:0]     valid;
  logic [LA-1:0]        ent_line [DEPTH];
  logic [LINE_BITS-1:0] ent_data [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;

  logic [LA-1:0]        req_line;
  logic                 hit;
  logic [PW-1:0]        hit_idx;
  logic [PW-1:0]        scan_idx;
  logic                 full;
  logic                 unused_offset_bits;

  assign req_line           = mem_address[15:OFFSET_BITS];
  assign unused_offset_bits = ^mem_address[OFFSET_BITS-1:0];
  assign full               = (count == CW'(DEPTH));
  assign empty              = (count == '0);

  // Scan oldest to newest so a later match overrides an earlier one:
  // the newest entry wins if duplicates ever existed.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if (valid[scan_idx] && (ent_line[scan_idx] == req_line)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_line[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            if (hit) begin
              // Coalesce into the existing entry; occupancy unchanged.
              ent_data[hit_idx] <= mem_wdata;
              mem_resp          <= 1'b1;
              state             <= ACK;
            end else if (!full) begin
              valid[tail]    <= 1'b1;
              ent_line[tail] <= req_line;
              ent_data[tail] <= mem_wdata;
              tail           <= tail + PW'(1);
              count          <= count + CW'(1);
              mem_resp       <= 1'b1;
              state          <= ACK;
            end else begin
              // Full: free the head slot; the held write is retried in IDLE afterwards.
              pmem_write   <= 1'b1;
              pmem_address <= {ent_line[head], {OFFSET_BITS{1'b0}}};
              pmem_wdata   <= ent_data[head];
              state        <= DRAIN;
            end
          end else if (mem_read) begin
`ifdef WB_READ_FWD_EN
            if (hit) begin
              mem_rdata <= ent_data[hit_idx];
              mem_resp  <= 1'b1;
              state     <= ACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_line, {OFFSET_BITS{1'b0}}};
              state        <= MEM_RD;
            end
`else
            // No read-path comparator: empty the buffer first so memory is current.
            if (!empty) begin
              pmem_write   <= 1'b1;
              pmem_address <= {ent_line[head], {OFFSET_BITS{1'b0}}};
              pmem_wdata   <= ent_data[head];
              state        <= DRAIN;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_line, {OFFSET_BITS{1'b0}}};
              state        <= MEM_RD;
            end
`endif
          end else if (!empty) begin
            pmem_write   <= 1'b1;
            pmem_address <= {ent_line[head], {OFFSET_BITS{1'b0}}};
            pmem_wdata   <= ent_data[head];
            state        <= DRAIN;
          end
        end
        ACK: begin
          mem_resp <= 1'b0;
          state    <= IDLE;
        end
        MEM_RD: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            mem_rdata <= pmem_rdata;
            mem_resp  <= 1'b1;
            state     <= ACK;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write  <= 1'b0;
            valid[head] <= 1'b0;
            head        <= head + PW'(1);
            count       <= count - CW'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
